spad_window_reader: RTL and testbench
=====================================

// Module: spad_window_reader
// PURPOSE
//  Read-side controller for the scratchpad memory (KERNEL_SIZE asymmetric FIFO lines, 16b out per line).
//  Drives the one-line-at-a-time rd_mem_line/rd_en interface and pops one feature per line per column.
//  Assembles stride-1 KxK sliding windows and hands them to the conv engine over valid/ready.
//  Sits between scratchpad_mem and the PE array, alongside the feature loader that fills the lines.
// PARAMETERS
//  KERNEL_SIZE    `KERNEL_SIZE (5)    lines per scratchpad and window edge K
//  FEATURE_WIDTH  `FEATURE_WIDTH (16) bits per feature
//  SPAD_RD_LAT    2                   cycles from last CLEAR cycle to valid spad_data
//  DIM_W          8                   width of cfg_cols / cfg_rows
// PORTS
//  clk          in   1           clock
//  rst          in   1           synchronous reset, active-high
//  start        in   1           pulse; latches cfg_*; ignored unless idle
//  cfg_cols     in   DIM_W       columns per row to drain
//  cfg_rows     in   DIM_W       rows (column sweeps) to drain
//  spad_rd_line out  4           -> scratchpad rd_mem_line
//  spad_rd_en   out  1           -> scratchpad rd_en
//  spad_data    in   K*FW        <- scratchpad data_out, line l at [l*FW +: FW]
//  spad_empty   in   1           <- scratchpad group_empty
//  win_data     out  K*K*FW      window; feature(col c, line l) at [(c*K+l)*FW +: FW], c=0 oldest
//  win_valid    out  1           window valid; held until win_ready
//  win_ready    in   1           consumer accept
//  busy         out  1           high from reset/start until done
//  done         out  1           one-cycle pulse after last row
// BEHAVIOUR
//  Reset: spad_rd_en=0, spad_rd_line=0, win_valid=0, win_data=0, done=0, busy=1, all counters 0; enter FLUSH.
//  Scratchpad per-line read enables are sticky registers: a line only clears when re-addressed with rd_en=0.
//  FLUSH: K cycles, line=0..K-1, rd_en=0 -> IDLE, busy=0. Also entered from rst asserted mid-operation.
//  IDLE: on start latch cfg; cfg_cols==0 or cfg_rows==0 -> done pulse, stay IDLE; else busy=1, ISSUE line 0.
//  ISSUE(l): stall (rd_en=0, line=l) while spad_empty; else rd_en=1, line=l for one cycle -> CLEAR(l).
//  CLEAR(l): rd_en=0, line=l for one cycle (exactly one pop per line) -> ISSUE(l+1), or WAIT after l=K-1.
//  Column fetch = 2K cycles + stalls; WAIT counts SPAD_RD_LAT cycles -> CAPTURE.
//  CAPTURE: shift spad_data in as newest column (c=K-1), older columns move down c-1; fill=min(fill+1,K);
//   col_cnt++. fill==K -> EMIT, else next column (ISSUE 0) or row end.
//  EMIT: win_valid=1, win_data stable until win_ready; accepted same cycle as valid -> win_valid=0 next cycle.
//   No ISSUE while EMIT pending (back-pressure stops scratchpad pops).
//  Row end (col_cnt==cfg_cols after CAPTURE/EMIT): col_cnt=0, fill=0, window cleared, row_cnt++;
//   row_cnt==cfg_rows -> done pulse 1 cycle, busy=0, IDLE; else ISSUE 0.
//  Windows per row = cfg_cols-K+1; cfg_cols<K -> columns still drained, zero windows, done still pulses.
//  start while busy ignored. Counters DIM_W bits, no wrap (bounded by cfg).
// STRUCTURE
//  Shared package/header (network_para.vh): KERNEL_SIZE, FEATURE_WIDTH, state encodings SWR_FLUSH,
//   SWR_IDLE, SWR_ISSUE, SWR_CLEAR, SWR_WAIT, SWR_CAPTURE, SWR_EMIT.
//  One sub-module: spad_window_shift (K-column shift register with clear, capture enable, win_data out).
//  FSM, line/latency/column/row counters in top.
// TESTING
//  Reset -> busy=1 for K cycles, spad_rd_en=0, lines 0..4 sequenced, then busy=0, win_valid=0.
//  K=5, cols=7, rows=1, win_ready=1, spad model line l col c = {l,c} -> 3 windows, 1st = cols 0-4, done once.
//  Single column fetch: rd_en pattern 1,0 per line 0..4 = exactly 5 pops, each line popped once.
//  spad_empty held 20 cycles mid-column -> rd_en=0 throughout stall, no duplicate/lost pop, data correct.
//  win_ready=0 for 10 cycles -> win_valid/win_data stable, no new rd_en; resumes after accept.
//  cols=3 (<K), rows=2 -> 6 column fetches, 0 windows, done pulse; rst mid-row -> FLUSH then IDLE.

Source files
------------

// File: rtl/spad_window_reader_pkg.sv
// Shared constants and FSM encoding for the scratchpad window reader.
package spad_window_reader_pkg;
    localparam int KERNEL_SIZE   = 5;
    localparam int FEATURE_WIDTH = 16;
    localparam int SPAD_RD_LAT   = 2;
    localparam int DIM_W         = 8;
    localparam int LINE_W        = 4;
    localparam int FILL_W        = $clog2(KERNEL_SIZE + 1);
    localparam int LAT_W         = $clog2(SPAD_RD_LAT + 1);

    typedef enum logic [2:0] {
        SWR_FLUSH,
        SWR_IDLE,
        SWR_ISSUE,
        SWR_CLEAR,
        SWR_WAIT,
        SWR_CAPTURE,
        SWR_EMIT
    } swr_state_e;
endpackage

// File: rtl/spad_window_reader_if.sv
// Scratchpad read port plus window valid/ready channel seen by the window reader.
interface spad_window_reader_if;
    import spad_window_reader_pkg::*;

    logic [LINE_W-1:0]                                spad_rd_line;
    logic                                             spad_rd_en;
    logic [KERNEL_SIZE*FEATURE_WIDTH-1:0]             spad_data;
    logic                                             spad_empty;
    logic [KERNEL_SIZE*KERNEL_SIZE*FEATURE_WIDTH-1:0] win_data;
    logic                                             win_valid;
    logic                                             win_ready;

    modport master (
        output spad_rd_line, spad_rd_en, win_data, win_valid,
        input  spad_data, spad_empty, win_ready
    );

    modport slave (
        input  spad_rd_line, spad_rd_en, win_data, win_valid,
        output spad_data, spad_empty, win_ready
    );
endinterface

// File: rtl/spad_window_reader_shift.sv
// K-column window shift register: newest column enters at the top, column 0 is oldest.
module spad_window_shift
    import spad_window_reader_pkg::*;
#(
    parameter int K  = KERNEL_SIZE,
    parameter int FW = FEATURE_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [K*FW-1:0]   col_in,
    output logic [K*K*FW-1:0] win_data
);
    localparam int COL_W = K * FW;
    localparam int WIN_W = K * COL_W;

    logic [WIN_W-1:0] win_q, win_d;

    // Clear wins over capture so a row end discards any partial window.
    always_comb begin
        win_d = win_q;
        if (clr) begin
            win_d = '0;
        end else if (en) begin
            win_d = {col_in, win_q[WIN_W-1:COL_W]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            win_q <= '0;
        end else begin
            win_q <= win_d;
        end
    end

    assign win_data = win_q;
endmodule

// File: rtl/spad_window_reader.sv
// Drains scratchpad lines one feature per line per column and emits stride-1 KxK windows.
module spad_window_reader
    import spad_window_reader_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [DIM_W-1:0]     cfg_cols,
    input  logic [DIM_W-1:0]     cfg_rows,
    spad_window_reader_if.master bus,
    output logic                 busy,
    output logic                 done
);
    swr_state_e        state_q, state_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic [DIM_W-1:0]  col_q, col_d;
    logic [DIM_W-1:0]  row_q, row_d;
    logic [DIM_W-1:0]  cols_q, cols_d;
    logic [DIM_W-1:0]  rows_q, rows_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic              done_q, done_d;
    logic              shift_en, shift_clr, row_end;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SWR_FLUSH;
            line_q  <= '0;
            lat_q   <= '0;
            col_q   <= '0;
            row_q   <= '0;
            cols_q  <= '0;
            rows_q  <= '0;
            fill_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            lat_q   <= lat_d;
            col_q   <= col_d;
            row_q   <= row_d;
            cols_q  <= cols_d;
            rows_q  <= rows_d;
            fill_q  <= fill_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        line_d    = line_q;
        lat_d     = lat_q;
        col_d     = col_q;
        row_d     = row_q;
        cols_d    = cols_q;
        rows_d    = rows_q;
        fill_d    = fill_q;
        done_d    = 1'b0;
        shift_en  = 1'b0;
        shift_clr = 1'b0;
        row_end   = 1'b0;

        case (state_q)
            SWR_FLUSH: begin
                line_d = line_q + 1'b1;
                if (line_q == LINE_W'(KERNEL_SIZE - 1)) begin
                    state_d = SWR_IDLE;
                    line_d  = '0;
                end
            end
            SWR_IDLE: begin
                if (start) begin
                    cols_d = cfg_cols;
                    rows_d = cfg_rows;
                    if (cfg_cols == '0 || cfg_rows == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d   = SWR_ISSUE;
                        line_d    = '0;
                        col_d     = '0;
                        row_d     = '0;
                        fill_d    = '0;
                        shift_clr = 1'b1;
                    end
                end
            end
            SWR_ISSUE: begin
                if (!bus.spad_empty) begin
                    state_d = SWR_CLEAR;
                end
            end
            // Line stays at K-1 through WAIT/CAPTURE; re-clearing it is harmless.
            SWR_CLEAR: begin
                if (line_q == LINE_W'(KERNEL_SIZE - 1)) begin
                    state_d = SWR_WAIT;
                    lat_d   = '0;
                end else begin
                    state_d = SWR_ISSUE;
                    line_d  = line_q + 1'b1;
                end
            end
            SWR_WAIT: begin
                if (lat_q == LAT_W'(SPAD_RD_LAT - 1)) begin
                    state_d = SWR_CAPTURE;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            SWR_CAPTURE: begin
                shift_en = 1'b1;
                fill_d   = (fill_q == FILL_W'(KERNEL_SIZE)) ? fill_q : fill_q + 1'b1;
                col_d    = col_q + 1'b1;
                if (fill_d == FILL_W'(KERNEL_SIZE)) begin
                    state_d = SWR_EMIT;
                end else if (col_d == cols_q) begin
                    row_end = 1'b1;
                end else begin
                    state_d = SWR_ISSUE;
                    line_d  = '0;
                end
            end
            SWR_EMIT: begin
                if (bus.win_ready) begin
                    if (col_q == cols_q) begin
                        row_end = 1'b1;
                    end else begin
                        state_d = SWR_ISSUE;
                        line_d  = '0;
                    end
                end
            end
            default: begin
                state_d = SWR_FLUSH;
                line_d  = '0;
            end
        endcase

        // End of a column sweep: drop the partial window and move to the next row.
        if (row_end) begin
            col_d     = '0;
            fill_d    = '0;
            shift_clr = 1'b1;
            row_d     = row_q + 1'b1;
            line_d    = '0;
            if (row_d == rows_q) begin
                state_d = SWR_IDLE;
                done_d  = 1'b1;
            end else begin
                state_d = SWR_ISSUE;
            end
        end
    end

    spad_window_shift #(
        .K  (KERNEL_SIZE),
        .FW (FEATURE_WIDTH)
    ) u_shift (
        .clk      (clk),
        .rst      (rst),
        .clr      (shift_clr),
        .en       (shift_en),
        .col_in   (bus.spad_data),
        .win_data (bus.win_data)
    );

    assign bus.spad_rd_line = line_q;
    assign bus.spad_rd_en   = (state_q == SWR_ISSUE) && !bus.spad_empty;
    assign bus.win_valid    = (state_q == SWR_EMIT);
    assign busy             = (state_q != SWR_IDLE);
    assign done             = done_q;
endmodule

// File: tb/tb_spad_window_reader.sv
// Directed bench for spad_window_reader with a pop-counting scratchpad model (line l, col c -> {l,c}).
module tb_spad_window_reader;
    import spad_window_reader_pkg::*;

    localparam int K     = KERNEL_SIZE;
    localparam int FW    = FEATURE_WIDTH;
    localparam int WIN_W = K * K * FW;

    typedef struct {
        int cols;
        int rows;
        int exp_windows;
        int exp_pops;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [DIM_W-1:0] cfg_cols;
    logic [DIM_W-1:0] cfg_rows;
    logic             busy;
    logic             done;
    logic             job_clr;

    int               checks = 0;
    int               errors = 0;
    int               pops_model [K];
    logic [FW-1:0]    spad_line [K];
    int               pops_mon [K];
    int               done_cnt;
    logic [WIN_W-1:0] got_windows [$];
    vec_t             vecs [6];

    spad_window_reader_if bus ();

    spad_window_reader dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .cfg_cols (cfg_cols),
        .cfg_rows (cfg_rows),
        .bus      (bus),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Scratchpad model: a pop on line l hands out that line's next column index.
    always @(posedge clk) begin
        if (job_clr) begin
            for (int l = 0; l < K; l++) begin
                pops_model[l] <= 0;
                spad_line[l]  <= '0;
            end
        end else if (bus.spad_rd_en && bus.spad_rd_line < LINE_W'(K)) begin
            pops_model[int'(bus.spad_rd_line)] <= pops_model[int'(bus.spad_rd_line)] + 1;
            spad_line[int'(bus.spad_rd_line)]  <= {8'(bus.spad_rd_line), 8'(pops_model[int'(bus.spad_rd_line)])};
        end
    end

    always_comb begin
        bus.spad_data = '0;
        for (int l = 0; l < K; l++) begin
            bus.spad_data[l*FW +: FW] = spad_line[l];
        end
    end

    always @(negedge clk) begin
        if (job_clr) begin
            for (int l = 0; l < K; l++) pops_mon[l] = 0;
            done_cnt = 0;
            got_windows.delete();
        end else begin
            if (bus.spad_rd_en && bus.spad_rd_line < LINE_W'(K)) pops_mon[int'(bus.spad_rd_line)]++;
            if (bus.win_valid && bus.win_ready) got_windows.push_back(bus.win_data);
            if (done) done_cnt++;
        end
    end

    function automatic logic [WIN_W-1:0] expWindow(input int base);
        logic [WIN_W-1:0] w;
        w = '0;
        for (int c = 0; c < K; c++) begin
            for (int l = 0; l < K; l++) begin
                w[(c*K+l)*FW +: FW] = {8'(l), 8'(base + c)};
            end
        end
        return w;
    endfunction

    task automatic checkOutput(input string name, input logic [WIN_W-1:0] got, input logic [WIN_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic checkReset();
        for (int i = 0; i < K; i++) begin
            @(negedge clk);
            checkOutput("flush_busy", busy, 1);
            checkOutput("flush_line", bus.spad_rd_line, i);
            checkOutput("flush_rd_en", bus.spad_rd_en, 0);
        end
        @(negedge clk);
        checkOutput("idle_busy", busy, 0);
        checkOutput("idle_win_valid", bus.win_valid, 0);
        checkOutput("idle_win_data", bus.win_data, 0);
        checkOutput("idle_done", done, 0);
    endtask

    task automatic startJob(input int cols, input int rows);
        @(posedge clk);
        #1 job_clr = 1'b1;
        cfg_cols = DIM_W'(cols);
        cfg_rows = DIM_W'(rows);
        @(posedge clk);
        #1 job_clr = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic waitDone(input int bound);
        bit seen = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        if (seen) begin
            checkOutput("busy_at_done", busy, 0);
        end else begin
            checks++;
            errors++;
            $display("[TB] FAIL done_timeout: no done within %0d cycles", bound);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic checkJob(input vec_t v);
        int wpr;
        int n;
        wpr = (v.cols >= K) ? v.cols - K + 1 : 0;
        checkOutput("win_count", got_windows.size(), v.exp_windows);
        for (int l = 0; l < K; l++) checkOutput("pops_per_line", pops_mon[l], v.exp_pops);
        checkOutput("done_count", done_cnt, 1);
        n = (got_windows.size() < v.exp_windows) ? got_windows.size() : v.exp_windows;
        if (wpr > 0) begin
            for (int i = 0; i < n; i++) begin
                checkOutput("win_data", got_windows[i], expWindow((i / wpr) * v.cols + (i % wpr)));
            end
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        startJob(v.cols, v.rows);
        waitDone(2000);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [WIN_W-1:0] held;
        int               rden_bad;
        int               valid_bad;
        int               data_bad;
        bit               seen;

        vecs[0] = '{7, 1, 3, 7};
        vecs[1] = '{5, 1, 1, 5};
        vecs[2] = '{3, 2, 0, 6};
        vecs[3] = '{6, 2, 4, 12};
        vecs[4] = '{0, 3, 0, 0};
        vecs[5] = '{4, 0, 0, 0};

        rst            = 1'b1;
        start          = 1'b0;
        cfg_cols       = '0;
        cfg_rows       = '0;
        job_clr        = 1'b0;
        bus.spad_empty = 1'b0;
        bus.win_ready  = 1'b1;

        $display("[TB] reset and flush");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        checkReset();

        $display("[TB] table-driven jobs");
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i]);
            checkJob(vecs[i]);
        end

        $display("[TB] single column fetch pattern");
        startJob(1, 1);
        for (int i = 0; i < 2 * K; i++) begin
            @(negedge clk);
            checkOutput("fetch_pattern", {bus.spad_rd_en, bus.spad_rd_line}, {1'(i % 2 == 0), 4'(i / 2)});
        end
        waitDone(200);
        checkJob('{1, 1, 0, 1});

        $display("[TB] empty stall mid-column");
        startJob(5, 1);
        repeat (3) @(posedge clk);
        #1 bus.spad_empty = 1'b1;
        rden_bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.spad_rd_en) rden_bad++;
        end
        checkOutput("stall_rd_en", rden_bad, 0);
        checkOutput("stall_line", bus.spad_rd_line, 2);
        @(posedge clk);
        #1 bus.spad_empty = 1'b0;
        waitDone(500);
        checkJob('{5, 1, 1, 5});

        $display("[TB] window back-pressure");
        bus.win_ready = 1'b0;
        startJob(6, 1);
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus.win_valid) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput("bp_valid_seen", seen, 1);
        held = bus.win_data;
        @(posedge clk);
        #1 cfg_cols = DIM_W'(1);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        rden_bad  = 0;
        valid_bad = 0;
        data_bad  = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.spad_rd_en) rden_bad++;
            if (!bus.win_valid) valid_bad++;
            if (bus.win_data !== held) data_bad++;
        end
        checkOutput("bp_rd_en", rden_bad, 0);
        checkOutput("bp_valid_held", valid_bad, 0);
        checkOutput("bp_data_stable", data_bad, 0);
        checkOutput("bp_held_window", held, expWindow(0));
        @(posedge clk);
        #1 bus.win_ready = 1'b1;
        waitDone(500);
        checkJob('{6, 1, 2, 6});

        $display("[TB] reset mid-row");
        startJob(7, 2);
        repeat (30) @(posedge clk);
        #1 checkOutput("busy_midrow", busy, 1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        checkReset();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
